// File: rtl/filter3x3_if.sv
// FIFO-side handshake bundle for filter3x3: upstream pop port, downstream push port and mode.
// The slave modport is the filter; the master modport is the surrounding FIFOs and control.
interface filter3x3_if #(
  parameter int unsigned DWIDTH_IN  = 8,
  parameter int unsigned DWIDTH_OUT = 8
);
  logic [1:0]            mode;
  logic                  fifo_in_rd_en;
  logic [DWIDTH_IN-1:0]  fifo_in_dout;
  logic                  fifo_in_empty;
  logic                  fifo_out_wr_en;
  logic [DWIDTH_OUT-1:0] fifo_out_din;
  logic                  fifo_out_full;

  modport master (
    output mode,
    output fifo_in_dout,
    output fifo_in_empty,
    output fifo_out_full,
    input  fifo_in_rd_en,
    input  fifo_out_wr_en,
    input  fifo_out_din
  );

  modport slave (
    input  mode,
    input  fifo_in_dout,
    input  fifo_in_empty,
    input  fifo_out_full,
    output fifo_in_rd_en,
    output fifo_out_wr_en,
    output fifo_out_din
  );
endinterface

// File: rtl/filter3x3.sv
// Streaming 3x3 filter (Sobel / Gaussian / passthrough) with two internal line buffers.
// Define FILTER3X3_GAUSS_EN to build the Gaussian kernel; otherwise mode 1 is passthrough.
module filter3x3 #(
  parameter int unsigned DWIDTH_IN  = 8,
  parameter int unsigned DWIDTH_OUT = 8,
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540
) (
  input logic        clk,
  input logic        rst_n,
  filter3x3_if.slave bus
);
  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);
  localparam int unsigned CntW = $clog2(IMG_WIDTH + 2);
  localparam int unsigned SobW = DWIDTH_IN + 3;
  localparam int unsigned SumW = DWIDTH_IN + 5;

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(IMG_WIDTH);
  localparam logic [SumW-1:0] OutMax  = SumW'((1 << DWIDTH_OUT) - 1);

  typedef enum logic [1:0] {StFill, StRun, StFlush} state_e;

  state_e                state_q;
  logic [RowW-1:0]       row_q, row_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [CntW-1:0]       cnt_q;
  logic [1:0]            mode_q;

  logic [DWIDTH_IN-1:0]  lb0_q [IMG_WIDTH];
  logic [DWIDTH_IN-1:0]  lb1_q [IMG_WIDTH];
  logic [DWIDTH_IN-1:0]  tap_q [3][2];
  logic [DWIDTH_IN-1:0]  win   [3][3];

  logic                  rd_en, wr_en, interior;
  logic [DWIDTH_OUT-1:0] din, result;

  logic signed [SobW-1:0] gx, gy;
  logic [SobW-1:0]        gx_abs, gy_abs;
  logic [SumW-1:0]        sob_mag;
`ifdef FILTER3X3_GAUSS_EN
  logic [SumW-1:0]        gauss;
`endif

  function automatic logic [DWIDTH_OUT-1:0] sat(input logic [SumW-1:0] v);
    return (v > OutMax) ? DWIDTH_OUT'(OutMax) : DWIDTH_OUT'(v);
  endfunction

  // Window rows are (row-2, row-1, row); right column is the pixel being read right now.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win[i][0] = tap_q[i][0];
      win[i][1] = tap_q[i][1];
    end
    win[0][2] = lb1_q[col_q];
    win[1][2] = lb0_q[col_q];
    win[2][2] = bus.fifo_in_dout;
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= bus.fifo_in_dout;
      for (int i = 0; i < 3; i++) begin
        tap_q[i][0] <= tap_q[i][1];
        tap_q[i][1] <= win[i][2];
      end
    end
  end

  always_comb begin
    gx = SobW'(win[0][2]) + (SobW'(win[1][2]) << 1) + SobW'(win[2][2])
       - SobW'(win[0][0]) - (SobW'(win[1][0]) << 1) - SobW'(win[2][0]);
    gy = SobW'(win[2][0]) + (SobW'(win[2][1]) << 1) + SobW'(win[2][2])
       - SobW'(win[0][0]) - (SobW'(win[0][1]) << 1) - SobW'(win[0][2]);
    gx_abs  = gx[SobW-1] ? SobW'(-gx) : SobW'(gx);
    gy_abs  = gy[SobW-1] ? SobW'(-gy) : SobW'(gy);
    sob_mag = (SumW'(gx_abs) + SumW'(gy_abs)) >> 1;
  end

`ifdef FILTER3X3_GAUSS_EN
  always_comb begin
    gauss = (SumW'(win[0][0]) + (SumW'(win[0][1]) << 1) + SumW'(win[0][2])
          + (SumW'(win[1][0]) << 1) + (SumW'(win[1][1]) << 2) + (SumW'(win[1][2]) << 1)
          + SumW'(win[2][0]) + (SumW'(win[2][1]) << 1) + SumW'(win[2][2])) >> 4;
  end
`endif

  // Output pixel is (row-1, col-1); it is interior only once two rows and two columns are in.
  assign interior = (row_q >= RowW'(2)) && (col_q >= ColW'(2));

  always_comb begin
    result = '0;
    if (interior) begin
      case (mode_q)
        2'd0:    result = sat(sob_mag);
`ifdef FILTER3X3_GAUSS_EN
        2'd1:    result = sat(gauss);
`endif
        default: result = DWIDTH_OUT'(win[1][1]);
      endcase
    end
  end

  always_comb begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    din   = '0;
    if (rst_n) begin
      case (state_q)
        StFill:  rd_en = !bus.fifo_in_empty;
        StRun: begin
          rd_en = !bus.fifo_in_empty && !bus.fifo_out_full;
          wr_en = rd_en;
          din   = result;
        end
        StFlush: wr_en = !bus.fifo_out_full;
        default: ;
      endcase
    end
  end

  assign bus.fifo_in_rd_en  = rd_en;
  assign bus.fifo_out_wr_en = wr_en;
  assign bus.fifo_out_din   = din;

  always_comb begin
    col_d = (col_q == ColLast) ? '0 : col_q + ColW'(1);
    row_d = (col_q == ColLast) ? row_q + RowW'(1) : row_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'd0;
    end else begin
      if (rd_en && (row_q == '0) && (col_q == '0)) begin
        mode_q <= bus.mode;
      end
      case (state_q)
        StFill: begin
          if (rd_en) begin
            row_q <= row_d;
            col_q <= col_d;
            if (cnt_q == CntLast) begin
              state_q <= StRun;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StRun: begin
          if (rd_en) begin
            if ((row_q == RowLast) && (col_q == ColLast)) begin
              state_q <= StFlush;
              row_q   <= '0;
              col_q   <= '0;
            end else begin
              row_q <= row_d;
              col_q <= col_d;
            end
          end
        end
        StFlush: begin
          if (wr_en) begin
            if (cnt_q == CntLast) begin
              state_q <= StFill;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end
endmodule

// File: tb/tb_filter3x3.sv
// Bench for filter3x3 on a 4x4 image: FIFO models, a frame-level reference model and
// directed plus randomized frames.
module tb_filter3x3;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  filter3x3_if #(.DWIDTH_IN(8), .DWIDTH_OUT(8)) bus ();

  filter3x3 #(
    .DWIDTH_IN (8),
    .DWIDTH_OUT(8),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int q[$];
  int pix[N];
  int out_log[N];
  int rdcnt, wrcnt, fmode, frames_done, first_wr_rd, flush_writes;
  int checks, errors;
  bit full_force;
  int bubble_pct, full_pct;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Expected output k of the current frame, from the pixels read so far.
  function automatic int model_out(input int k);
    int r, c, gx, gy, s;
    int p[3][3];
    int wt[3][3];
    wt = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
    r = k / W;
    c = k % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = pix[(r - 1 + i) * W + (c - 1 + j)];
    if (fmode == 0) begin
      gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
      gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
      if (gx < 0) gx = -gx;
      if (gy < 0) gy = -gy;
      return clamp255((gx + gy) / 2);
    end
`ifdef FILTER3X3_GAUSS_EN
    if (fmode == 1) begin
      s = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          s += wt[i][j] * p[i][j];
      return clamp255(s / 16);
    end
`endif
    return p[1][1];
  endfunction

  task automatic drive();
    bus.fifo_in_empty = (q.size() == 0) || ($urandom_range(99) < bubble_pct);
    bus.fifo_in_dout  = (q.size() > 0) ? 8'(q[0]) : 8'd0;
    bus.fifo_out_full = full_force || ($urandom_range(99) < full_pct);
  endtask

  task automatic cycle();
    int exp_rd, exp_wr;
    @(negedge clk);
    if (rdcnt < W + 1) begin
      exp_rd = !bus.fifo_in_empty;
      exp_wr = 0;
    end else if (rdcnt < N) begin
      exp_rd = !bus.fifo_in_empty && !bus.fifo_out_full;
      exp_wr = exp_rd;
    end else begin
      exp_rd = 0;
      exp_wr = !bus.fifo_out_full;
    end
    check("rd_en", 32'(bus.fifo_in_rd_en), exp_rd);
    check("wr_en", 32'(bus.fifo_out_wr_en), exp_wr);
    if (bus.fifo_in_rd_en === 1'b1) begin
      if (rdcnt == 0) fmode = bus.mode;
      if (rdcnt < N) pix[rdcnt] = bus.fifo_in_dout;
      rdcnt++;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (bus.fifo_out_wr_en === 1'b1) begin
      if (wrcnt == 0) first_wr_rd = rdcnt;
      if (bus.fifo_in_rd_en !== 1'b1) flush_writes++;
      if (wrcnt < N) begin
        check("pixel", 32'(bus.fifo_out_din), model_out(wrcnt));
        out_log[wrcnt] = bus.fifo_out_din;
      end
      wrcnt++;
    end
    if (rdcnt >= N && wrcnt >= N) begin
      check("first_write_read_count", first_wr_rd, W + 2);
      check("flush_writes", flush_writes, W + 1);
      frames_done++;
      rdcnt = 0;
      wrcnt = 0;
      first_wr_rd = -1;
      flush_writes = 0;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_frames(input int n);
    int target, budget;
    target = frames_done + n;
    budget = 200 * n;
    while (frames_done < target && budget > 0) begin
      cycle();
      budget--;
    end
    check("frames_within_budget", frames_done, target);
  endtask

  task automatic run_to_reads(input int n);
    int budget;
    budget = 200;
    while (rdcnt < n && budget > 0) begin
      cycle();
      budget--;
    end
    check("reads_within_budget", rdcnt, n);
  endtask

  task automatic load_frame(input int kind);
    for (int i = 0; i < N; i++) begin
      int r, c, v;
      r = i / W;
      c = i % W;
      case (kind)
        0:       v = 100;
        1:       v = (c >= 2) ? 200 : 0;
        2:       v = (r == 1 && c == 1) ? 160 : 0;
        default: v = int'($urandom_range(255));
      endcase
      q.push_back(v);
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.fifo_in_empty = 1'b0;
    bus.fifo_out_full = 1'b0;
    bus.fifo_in_dout  = 8'd55;
    #1;
    check("rd_en_in_reset", 32'(bus.fifo_in_rd_en), 0);
    check("wr_en_in_reset", 32'(bus.fifo_out_wr_en), 0);
    check("din_in_reset", 32'(bus.fifo_out_din), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rd_en_held_reset", 32'(bus.fifo_in_rd_en), 0);
    q.delete();
    rdcnt = 0;
    wrcnt = 0;
    first_wr_rd = -1;
    flush_writes = 0;
    rst_n = 1'b1;
    drive();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    frames_done = 0;
    full_force = 1'b0;
    bubble_pct = 0;
    full_pct = 0;
    bus.mode = 2'd0;
    bus.fifo_in_empty = 1'b1;
    bus.fifo_in_dout = 8'd0;
    bus.fifo_out_full = 1'b0;
    do_reset();

    // Constant frame, Sobel: everything zero.
    load_frame(0);
    run_frames(1);
    check("const_interior", out_log[5], 0);

    // Vertical edge, Sobel saturates.
    load_frame(1);
    run_frames(1);
    check("edge_1_1", out_log[5], 255);
    check("edge_1_2", out_log[6], 255);
    check("edge_2_1", out_log[9], 255);
    check("edge_2_2", out_log[10], 255);
    check("edge_border", out_log[4], 0);

    // Impulse, mode 1.
    bus.mode = 2'd1;
    load_frame(2);
    run_frames(1);
`ifdef FILTER3X3_GAUSS_EN
    check("impulse_1_1", out_log[5], 40);
    check("impulse_1_2", out_log[6], 20);
    check("impulse_2_1", out_log[9], 20);
    check("impulse_2_2", out_log[10], 10);
`else
    check("impulse_1_1", out_log[5], 160);
    check("impulse_1_2", out_log[6], 0);
    check("impulse_2_2", out_log[10], 0);
`endif

    // Downstream full for 10 cycles mid-RUN.
    bus.mode = 2'd0;
    load_frame(3);
    run_to_reads(8);
    full_force = 1'b1;
    drive();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("stall_rd_en", 32'(bus.fifo_in_rd_en), 0);
      check("stall_wr_en", 32'(bus.fifo_out_wr_en), 0);
    end
    full_force = 1'b0;
    drive();
    run_frames(1);

    // Mode changes at (2,0): this frame stays Sobel, next is passthrough.
    bus.mode = 2'd0;
    load_frame(3);
    load_frame(3);
    run_to_reads(8);
    bus.mode = 2'd2;
    run_frames(2);
    check("passthrough_interior", out_log[5], pix[5]);
    check("passthrough_border", out_log[0], 0);

    // Reset after 7 reads discards the partial frame.
    bus.mode = 2'd0;
    load_frame(3);
    run_to_reads(7);
    do_reset();
    load_frame(3);
    run_frames(1);

    // Randomized frames with upstream bubbles and downstream backpressure.
    bubble_pct = 20;
    full_pct = 15;
    for (int f = 0; f < 6; f++) begin
      bus.mode = 2'($urandom_range(3));
      load_frame(3);
      run_frames(1);
    end
    bus.mode = 2'd0;
    load_frame(3);
    load_frame(3);
    run_frames(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
